// File: rtl/rv32i_fetch_queue_if.sv
// Fetch/decode handshake bundle for the rv32i instruction fetch queue.
// Signal suffixes are from the queue's point of view.
interface rv32i_fetch_queue_if #(
   parameter int DPW = 32
);
   logic           push_valid_i;
   logic [DPW-1:0] push_pc_i;
   logic [DPW-1:0] push_instr_i;
   logic           push_ready_o;
   logic           stall_f_o;
   logic           pop_valid_o;
   logic [DPW-1:0] pop_pc_o;
   logic [DPW-1:0] pop_instr_o;
   logic           pop_ready_i;

   // Fetch/decode side of the pipeline.
   modport master (
      output push_valid_i, push_pc_i, push_instr_i, pop_ready_i,
      input  push_ready_o, stall_f_o, pop_valid_o, pop_pc_o, pop_instr_o
   );

   // The queue itself.
   modport slave (
      input  push_valid_i, push_pc_i, push_instr_i, pop_ready_i,
      output push_ready_o, stall_f_o, pop_valid_o, pop_pc_o, pop_instr_o
   );
endinterface

// File: rtl/rv32i_fetch_queue.sv
// Circular {PC, instruction} queue between fetch and decode.
// It supports full-queue pass-through, flush on redirect, and a NOP bubble when empty.
module rv32i_fetch_queue #(
   parameter int             DPW   = 32,
   parameter int             DEPTH = 4,
   parameter logic [DPW-1:0] NOP   = DPW'(32'h00000013)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   flush_i,
   rv32i_fetch_queue_if.slave     q,
   output logic [$clog2(DEPTH):0] count_o
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
      $error("rv32i_fetch_queue: DEPTH must be a power of two >= 2");
   end

   typedef struct packed {
      logic [DPW-1:0] pc;
      logic [DPW-1:0] instr;
   } entry_t;

   entry_t          mem_q [DEPTH];
   logic [AW-1:0]   wp_q, wp_d;
   logic [AW-1:0]   rp_q, rp_d;
   logic [CW-1:0]   count_q, count_d;
   logic            push_ready;
   logic            pop_valid;
   logic            push_fire;
   logic            pop_fire;
   logic            mem_we;

   // Pass-through when full: a slot frees up in the same cycle that decode pops.
   assign push_ready = (count_q < CW'(DEPTH)) | q.pop_ready_i;
   assign pop_valid  = (count_q != '0);
   assign push_fire  = q.push_valid_i & push_ready;
   assign pop_fire   = pop_valid & q.pop_ready_i;
   assign mem_we     = push_fire & ~flush_i;

   assign q.push_ready_o = push_ready;
   assign q.stall_f_o    = ~push_ready;
   assign q.pop_valid_o  = pop_valid;
   assign q.pop_pc_o     = pop_valid ? mem_q[rp_q].pc    : '0;
   assign q.pop_instr_o  = pop_valid ? mem_q[rp_q].instr : NOP;
   assign count_o        = count_q;

   always_comb begin
      // NOTE: every always_comb output gets a default first, so no path can infer a latch.
      wp_d    = wp_q;
      rp_d    = rp_q;
      count_d = count_q;
      if (flush_i) begin
         wp_d    = '0;
         rp_d    = '0;
         count_d = '0;
      end else begin
         if (push_fire) wp_d = wp_q + 1'b1;
         if (pop_fire)  rp_d = rp_q + 1'b1;
         unique case ({push_fire, pop_fire})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments, so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wp_q    <= '0;
         rp_q    <= '0;
         count_q <= '0;
      end else begin
         wp_q    <= wp_d;
         rp_q    <= rp_d;
         count_q <= count_d;
      end
   end

   // NOTE: the entry array is not reset; count gates every read, so stale contents are never visible.
   always_ff @(posedge clk) begin
      if (mem_we) mem_q[wp_q] <= '{pc: q.push_pc_i, instr: q.push_instr_i};
   end

   a_count_max: assert property (@(posedge clk) disable iff (!rst_n)
      count_q <= CW'(DEPTH));
   a_pop_nonempty: assert property (@(posedge clk) disable iff (!rst_n)
      pop_fire |-> count_q != '0);
endmodule

// File: tb/tb_rv32i_fetch_queue.sv
// Self-checking bench for rv32i_fetch_queue: a queue-based reference model is
// compared every cycle, and directed literal checks pin the model.
module tb_rv32i_fetch_queue;
   localparam int          DPW   = 32;
   localparam int          DEPTH = 4;
   localparam logic [31:0] NOP   = 32'h00000013;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       flush;
   logic [2:0] count;

   rv32i_fetch_queue_if #(.DPW(DPW)) fq_if ();

   rv32i_fetch_queue #(.DPW(DPW), .DEPTH(DEPTH), .NOP(NOP)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .flush_i (flush),
      .q       (fq_if),
      .count_o (count)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // The reference model is an ordered list of accepted {pc, instr} pairs.
   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
   } ent_t;
   ent_t mq[$];

   always @(posedge clk or negedge rst_n) begin : model_upd
      bit acc;
      bit pop_now;
      ent_t e;
      if (!rst_n) begin
         mq.delete();
      end else if (flush) begin
         mq.delete();
      end else begin
         acc     = fq_if.push_valid_i && (mq.size() < DEPTH || fq_if.pop_ready_i);
         pop_now = fq_if.pop_ready_i && (mq.size() != 0);
         if (pop_now) e = mq.pop_front();
         if (acc) begin
            e.pc    = fq_if.push_pc_i;
            e.instr = fq_if.push_instr_i;
            mq.push_back(e);
         end
      end
   end

   // The compare process runs on every cycle, after the stimulus settles on the falling edge.
   always @(negedge clk) begin : compare
      bit v;
      bit rdy;
      #2;
      v   = (mq.size() != 0);
      rdy = (mq.size() < DEPTH) || fq_if.pop_ready_i;
      check("pop_valid", 64'(fq_if.pop_valid_o), 64'(v));
      check("pop_pc", 64'(fq_if.pop_pc_o), v ? 64'(mq[0].pc) : 64'd0);
      check("pop_instr", 64'(fq_if.pop_instr_o), v ? 64'(mq[0].instr) : 64'(NOP));
      check("count", 64'(count), 64'(mq.size()));
      check("push_ready", 64'(fq_if.push_ready_o), 64'(rdy));
      check("stall_f", 64'(fq_if.stall_f_o), 64'(!rdy));
   end

   // Each drive sets the inputs on a falling edge; a following #3 lands after the compare process.
   task automatic drive(input logic pv, input logic [31:0] pc, input logic pr, input logic fl);
      @(negedge clk);
      fq_if.push_valid_i = pv;
      fq_if.push_pc_i    = pc;
      fq_if.push_instr_i = 32'hA000_0000 | pc;
      fq_if.pop_ready_i  = pr;
      flush              = fl;
      #3;
   endtask

   initial begin
      rst_n              = 1'b0;
      flush              = 1'b0;
      fq_if.push_valid_i = 1'b0;
      fq_if.push_pc_i    = '0;
      fq_if.push_instr_i = '0;
      fq_if.pop_ready_i  = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      // Idle after reset, including a pop request on an empty queue.
      drive(0, 0, 0, 0);
      check("idle_instr", 64'(fq_if.pop_instr_o), 64'h13);
      check("idle_count", 64'(count), 64'd0);
      drive(0, 0, 1, 0);
      check("idle_empty_pop_ready", 64'(fq_if.push_ready_o), 64'd1);
      drive(0, 0, 0, 0);
      check("idle_empty_pop_valid", 64'(fq_if.pop_valid_o), 64'd0);

      // A single push appears one cycle later and is then consumed.
      @(negedge clk);
      fq_if.push_valid_i = 1'b1;
      fq_if.push_pc_i    = 32'h0;
      fq_if.push_instr_i = 32'h00500093;
      fq_if.pop_ready_i  = 1'b0;
      #3;
      check("single_no_bypass", 64'(fq_if.pop_valid_o), 64'd0);
      drive(0, 0, 1, 0);
      check("single_valid", 64'(fq_if.pop_valid_o), 64'd1);
      check("single_instr", 64'(fq_if.pop_instr_o), 64'h00500093);
      check("single_count", 64'(count), 64'd1);
      drive(0, 0, 0, 0);
      check("single_drained", 64'(count), 64'd0);
      check("single_nop", 64'(fq_if.pop_instr_o), 64'h13);

      // Fill to capacity; the fifth push is stalled and dropped.
      for (int i = 0; i < 5; i++) drive(1, 32'(4 * i), 0, 0);
      check("fill_stall", 64'(fq_if.stall_f_o), 64'd1);
      drive(0, 0, 0, 0);
      check("fill_count", 64'(count), 64'd4);
      for (int i = 0; i < 4; i++) begin
         drive(0, 0, 1, 0);
         check("drain_order", 64'(fq_if.pop_pc_o), 64'(4 * i));
      end
      drive(0, 0, 0, 0);
      check("drain_empty", 64'(count), 64'd0);
      drive(1, 32'h14, 0, 0);
      drive(0, 0, 1, 0);
      check("wrap_head", 64'(fq_if.pop_pc_o), 64'h14);
      drive(0, 0, 0, 0);

      // Full pass-through: a push is accepted in the same cycle as a pop.
      for (int i = 0; i < 4; i++) drive(1, 32'(4 * i), 0, 0);
      drive(1, 32'h10, 1, 0);
      check("pt_ready", 64'(fq_if.push_ready_o), 64'd1);
      drive(0, 0, 0, 0);
      check("pt_head", 64'(fq_if.pop_pc_o), 64'h4);
      check("pt_count", 64'(count), 64'd4);

      // Flush has priority over a same-cycle push and pop.
      drive(0, 0, 1, 0);
      drive(1, 32'h20, 1, 1);
      check("pre_flush_count", 64'(count), 64'd3);
      drive(1, 32'h40, 0, 0);
      check("flush_count", 64'(count), 64'd0);
      check("flush_nop", 64'(fq_if.pop_instr_o), 64'h13);
      drive(1, 32'h50, 0, 0);
      check("post_flush_head", 64'(fq_if.pop_pc_o), 64'h40);
      drive(0, 0, 0, 0);
      check("pre_reset_count", 64'(count), 64'd2);

      // An asynchronous reset between edges empties the queue immediately.
      rst_n = 1'b0;
      #1;
      check("async_valid", 64'(fq_if.pop_valid_o), 64'd0);
      check("async_count", 64'(count), 64'd0);
      drive(0, 0, 0, 0);
      @(negedge clk);
      rst_n = 1'b1;
      drive(0, 0, 1, 0);
      drive(0, 0, 0, 0);
      check("final_count", 64'(count), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/rv32i_fetch_queue.md
Name: rv32i_fetch_queue

Overview:
- Instruction fetch queue between the fetch stage (PC register plus instruction memory) and the decode stage of the rv32i pipeline.
- Buffers fetched {PC, instruction} pairs so a decode-side stall does not immediately freeze fetch.
- Drives the fetch stall back to fetch when full.
- Supports a single-cycle flush on branch/jump redirect.
- Outputs a NOP bubble to decode whenever it has nothing valid.

Parameters:
- DPW, 32, datapath/instruction width in bits (from rv32i_pkg).
- DEPTH, 4, number of entries; must be a power of two, at least 2.
- NOP, 32'h00000013, instruction presented to decode when the queue is empty (addi x0,x0,0).

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- flush_i  input  1  redirect from execute; discards all entries.
- push_valid_i  input  1  fetch presents a valid instruction this cycle.
- push_pc_i  input  DPW  PC of the pushed instruction (PCF).
- push_instr_i  input  DPW  instruction word from instruction memory.
- push_ready_o  output  1  queue accepts a push this cycle.
- stall_f_o  output  1  equals ~push_ready_o; drives stallF.
- pop_valid_o  output  1  head entry valid toward decode.
- pop_pc_o  output  DPW  PC of head entry; 0 when empty.
- pop_instr_o  output  DPW  instruction of head entry; NOP when empty.
- pop_ready_i  input  1  decode consumes the head this cycle (~stallD).
- count_o  output  $clog2(DEPTH)+1  current number of valid entries.

Behaviour:
- Storage is a circular buffer with write pointer wp and read pointer rp, each $clog2(DEPTH) bits. Both wrap from DEPTH-1 to 0.
- count is a separate register, width $clog2(DEPTH)+1.
- Reset (rst_n=0, asynchronous): wp=0, rp=0, count=0. Consequently pop_valid_o=0, pop_pc_o=0, pop_instr_o=NOP, push_ready_o=1, stall_f_o=0, count_o=0. Entry contents are don't-care. Reset asserted mid-operation discards all entries immediately.
- push_fire = push_valid_i & push_ready_o.
- pop_fire = pop_valid_o & pop_ready_i.
- push_ready_o = (count < DEPTH) | pop_ready_i. Pass-through when full is allowed: a full queue accepts a push in the same cycle it pops. This is combinational from count and pop_ready_i only, with no dependence on push_valid_i.
- pop_valid_o = (count != 0). pop_pc_o and pop_instr_o are taken from mem[rp] when valid; otherwise they are 0 and NOP.
- No bypass: a push into an empty queue appears on pop_* in the next cycle (1-cycle latency).
- Per rising edge, when no flush:
  - push_fire: mem[wp] <= {push_pc_i, push_instr_i}, wp++.
  - pop_fire: rp++.
  - count += push_fire - pop_fire. Simultaneous push and pop leave count unchanged.
- Flush (flush_i=1) has priority over push and pop. Next edge: wp=0, rp=0, count=0. Any same-cycle push is dropped. A same-cycle pop is ignored; decode must also squash its own stage. The cycle after a flush shows pop_valid_o=0 with NOP.
- Push with push_ready_o=0: ignored, no state change. Fetch is held by stall_f_o.
- Pop request when empty (pop_ready_i=1, count=0): no state change. With an empty queue, push_ready_o is 1 regardless.
- count never exceeds DEPTH and never underflows. Assertions required: count<=DEPTH; pop_fire implies count>0.
- Ordering is strictly FIFO. PC/instruction pairing is preserved per entry.

Test Plan:
- Reset then idle: rst_n low 3 cycles, release, no pushes -> pop_valid_o=0, pop_instr_o=32'h00000013, pop_pc_o=0, push_ready_o=1, count_o=0 every cycle.
- Single push: push PC=0x0, instr=0x00500093 with pop_ready_i=0 -> next cycle pop_valid_o=1, pop_pc_o=0x0, pop_instr_o=0x00500093, count_o=1. Raise pop_ready_i -> following cycle count_o=0 and NOP.
- Fill and stall: pop_ready_i=0, push PCs 0x0,0x4,0x8,0xC,0x10 on consecutive cycles -> count_o reaches 4, stall_f_o=1 during the fifth push, and PC 0x10 is not stored. Then pop all -> PCs 0x0,0x4,0x8,0xC in order, and the queue wraps on the next push.
- Full pass-through: queue full (4), push PC 0x10 with pop_ready_i=1 -> push accepted, head advances to 0x4, count_o stays 4.
- Flush priority: count_o=3, assert flush_i together with push_valid_i=1 and pop_ready_i=1 -> next cycle count_o=0, pop_valid_o=0, NOP. A new push of PC 0x40 then appears at the head one cycle later.
- Async reset mid-stream: count_o=2, drop rst_n between clock edges -> pop_valid_o=0 and count_o=0 immediately, before the next clk edge.
